// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_W     = 32;
  localparam int STRB_W     = 4;
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word store with byte-lane write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents have no reset so they survive a core reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wstrb[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then
// performs the access once and holds the response until the core takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  dmem_state_t           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [STRB_W-1:0] lat_wstrb;

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [STRB_W-1:0] acc_wstrb;
  logic              acc_err;
  logic              enter_resp;

  logic              rsp_err_q;
  logic              rsp_load_q;
  logic [WORD_W-1:0] arr_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= WAIT_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (state_q == IDLE && req_valid) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // With zero wait states RESP is entered on the accept edge, so the access
  // must come straight from the request bus rather than the latch.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
    end
    acc_err    = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    enter_resp = (state_d == RESP) && (state_q != RESP);
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp && !acc_err),
    .we    (acc_we),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .wstrb (acc_wstrb),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else if (enter_resp) begin
      rsp_err_q  <= acc_err;
      rsp_load_q <= !acc_we && !acc_err;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_load_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with none, sharing clock, reset and request bus.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_ready;

  logic        req_valid2, req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_rdata2;
  logic        req_valid0, req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks;
  int errors;

  logic [31:0] rdata;
  logic        err;
  int          lat;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid2),
    .req_ready (req_ready2),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid2),
    .rsp_rdata (rsp_rdata2),
    .rsp_err   (rsp_err2),
    .rsp_ready (rsp_ready)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0),
    .rsp_ready (rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one request to the selected instance (sel=1 -> zero-wait instance),
  // returns the response and its latency in cycles counted from the accept edge.
  // hold>0 stalls the response and probes the request channel meanwhile.
  task automatic applyStimulus(input bit sel, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int hold, output logic [31:0] rd,
                               output logic er, output int cycles);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    rsp_ready = (hold == 0);
    if (sel) req_valid0 = 1'b1;
    else     req_valid2 = 1'b1;
    @(negedge clk);
    checkOutput("reqReady", 32'(sel ? req_ready0 : req_ready2), 32'd1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid2 = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(sel ? rsp_valid0 : rsp_valid2) && cycles < 40);
    rd = sel ? rsp_rdata0 : rsp_rdata2;
    er = sel ? rsp_err0 : rsp_err2;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      req_we     = 1'b1;
      req_addr   = 32'h10;
      req_wdata  = 32'hFFFF_FFFF;
      req_wstrb  = 4'hF;
      req_valid2 = 1'b1;
      @(negedge clk);
      checkOutput("bpValid", 32'(rsp_valid2), 32'd1);
      checkOutput("bpRdata", rsp_rdata2, rd);
      checkOutput("bpErr", 32'(rsp_err2), 32'(er));
      checkOutput("bpReqReady", 32'(req_ready2), 32'd0);
    end
    req_valid2 = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    req_valid2 = 1'b0;
    req_valid0 = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rstReqReady", 32'(req_ready2), 32'd1);
    checkOutput("rstRspValid", 32'(rsp_valid2), 32'd0);
    checkOutput("rstRdata", rsp_rdata2, 32'd0);
    checkOutput("rstErr", 32'(rsp_err2), 32'd0);
    checkOutput("rstReqReady0", 32'(req_ready0), 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rdata, err, lat);
    checkOutput("storeLatency", 32'(lat), 32'd3);
    checkOutput("storeErr", 32'(err), 32'd0);
    checkOutput("storeRdata", rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("loadRdata", rdata, 32'hDEAD_BEEF);
    checkOutput("loadErr", 32'(err), 32'd0);
    checkOutput("loadLatency", 32'(lat), 32'd3);

    applyStimulus(1'b0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, rdata, err, lat);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("partialRdata", rdata, 32'hDEAD_BEAA);

    applyStimulus(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("misalignErr", 32'(err), 32'd1);
    checkOutput("misalignRdata", rdata, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0, rdata, err, lat);
    checkOutput("word0StoreErr", 32'(err), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, 0, rdata, err, lat);
    checkOutput("rangeErr", 32'(err), 32'd1);
    checkOutput("rangeRdata", rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("word0Kept", rdata, 32'h0BAD_F00D);
    checkOutput("word0Err", 32'(err), 32'd0);

    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3, rdata, err, lat);
    checkOutput("bpLoadRdata", rdata, 32'hDEAD_BEAA);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("probeIgnored", rdata, 32'hDEAD_BEAA);

    applyStimulus(1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("noStrbErr", 32'(err), 32'd0);
    checkOutput("noStrbLatency", 32'(lat), 32'd3);

    // Store accepted, then reset lands one cycle later while still waiting.
    req_we     = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'hCAFE_F00D;
    req_wstrb  = 4'hF;
    req_valid2 = 1'b1;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    @(negedge clk);
    checkOutput("waitReqReady", 32'(req_ready2), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstValid", 32'(rsp_valid2), 32'd0);
    checkOutput("midRstReady", 32'(req_ready2), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("rstNoWrite", rdata, 32'hDEAD_BEAA);

    applyStimulus(1'b1, 1'b1, 32'h8, 32'h1111_2222, 4'hF, 0, rdata, err, lat);
    checkOutput("w0StoreLatency", 32'(lat), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("w0LoadLatency", 32'(lat), 32'd1);
    checkOutput("w0LoadRdata", rdata, 32'h1111_2222);
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("w0Load2Latency", 32'(lat), 32'd1);
    checkOutput("w0Load2Rdata", rdata, 32'h1111_2222);
    applyStimulus(1'b1, 1'b0, 32'h6, 32'h0, 4'h0, 0, rdata, err, lat);
    checkOutput("w0MisalignErr", 32'(err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
